multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences one instruction at a time through the shared datapath: the instruction/data memory port, the immediate generator, the ALU, the register file and the PC. It issues memory requests with a req/ack handshake and drives the immediate-format select. It also drives the enables for the instruction register, register file write and PC update. It sits between the memory interface and the datapath and is the only block that advances the PC.

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/opcode_class.sv | 28 ++
 rtl/multicycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: states, immediate
// formats (also consumed by the immediate generator), opcodes and classes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } ctrl_state_e;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Sequencing class: decides the path through EXEC/MEM/WB.
  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode decode into a sequencing class and immediate format.
module opcode_class
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_e  cls_o,
  output logic [2:0] imm_sel_o
);

  // Unsupported opcodes fall through to the illegal defaults.
  always_comb begin
    cls_o     = CLS_ILLEGAL;
    imm_sel_o = IMM_NONE;
    case (opcode_i)
      OPC_OP:     begin cls_o = CLS_ALU;    imm_sel_o = IMM_NONE; end
      OPC_OP_IMM: begin cls_o = CLS_ALU;    imm_sel_o = IMM_I;    end
      OPC_LOAD:   begin cls_o = CLS_LOAD;   imm_sel_o = IMM_I;    end
      OPC_STORE:  begin cls_o = CLS_STORE;  imm_sel_o = IMM_S;    end
      OPC_BRANCH: begin cls_o = CLS_BRANCH; imm_sel_o = IMM_B;    end
      OPC_LUI:    begin cls_o = CLS_ALU;    imm_sel_o = IMM_U;    end
      OPC_AUIPC:  begin cls_o = CLS_ALU;    imm_sel_o = IMM_U;    end
      OPC_JAL:    begin cls_o = CLS_JUMP;   imm_sel_o = IMM_J;    end
      OPC_JALR:   begin cls_o = CLS_JUMP;   imm_sel_o = IMM_I;    end
      default:    ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing with
// req/ack memory handshakes. Outputs are combinational state decodes.
// Optional memory-wait timeout enabled by defining CTRL_TIMEOUT_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_br_taken,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  output logic        o_imem_req,
  output logic        o_ir_en,
  output logic        o_dmem_req,
  output logic        o_dmem_wren,
  output logic [2:0]  o_imm_sel,
  output logic        o_rd_wren,
  output logic        o_pc_en,
  output logic        o_pc_sel,
  output logic        o_illegal,
  output logic        o_bus_err
);

  ctrl_state_e state_q, state_d;
  op_class_e   cls;
  logic [2:0]  dec_imm_sel;
  logic        illegal_q;
  logic        set_illegal_c;
  logic        trap_timeout_c;
  logic        wait_expired_c;
  logic        unused_instr_bits;

  // Only the opcode field steers sequencing.
  assign unused_instr_bits = ^i_instr[31:7];

  opcode_class u_opcode_class (
    .opcode_i  (i_instr[6:0]),
    .cls_o     (cls),
    .imm_sel_o (dec_imm_sel)
  );

  // State register; async reset lands in BOOT and drops all requests.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_BOOT;
    else          state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    o_imem_req     = 1'b0;
    o_ir_en        = 1'b0;
    o_dmem_req     = 1'b0;
    o_dmem_wren    = 1'b0;
    o_imm_sel      = IMM_I;
    o_rd_wren      = 1'b0;
    o_pc_en        = 1'b0;
    o_pc_sel       = 1'b0;
    set_illegal_c  = 1'b0;
    trap_timeout_c = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_en = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_expired_c) begin
          trap_timeout_c = 1'b1;
          state_d        = ST_TRAP;
        end
      end
      ST_DECODE: begin
        o_imm_sel = dec_imm_sel;
        if (cls == CLS_ILLEGAL) begin
          set_illegal_c = 1'b1;
          state_d       = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        o_imm_sel = dec_imm_sel;
        case (cls)
          CLS_BRANCH: begin
            o_pc_en  = 1'b1;
            o_pc_sel = i_br_taken;
            state_d  = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        o_imm_sel   = dec_imm_sel;
        o_dmem_req  = 1'b1;
        o_dmem_wren = (cls == CLS_STORE);
        if (i_dmem_ack) begin
          if (cls == CLS_STORE) begin
            o_pc_en = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_expired_c) begin
          trap_timeout_c = 1'b1;
          state_d        = ST_TRAP;
        end
      end
      ST_WB: begin
        o_imm_sel = dec_imm_sel;
        o_rd_wren = 1'b1;
        o_pc_en   = 1'b1;
        o_pc_sel  = (cls == CLS_JUMP);
        state_d   = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
  end

  // Sticky illegal-opcode flag; only reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           illegal_q <= 1'b0;
    else if (set_illegal_c) illegal_q <= 1'b1;
  end

  assign o_illegal = illegal_q;

`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q;

  // Limit is hit on the cycle whose missing ack would bring the count to it.
  assign wait_expired_c = (32'(wait_cnt_q) + 32'd1) >= 32'(TIMEOUT_CYCLES);

  // Count ack-less cycles while waiting; any other state clears the count.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == ST_FETCH && !i_imem_ack) ||
        (state_q == ST_MEM && !i_dmem_ack))
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  // Wait counter and sticky bus-error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (trap_timeout_c) bus_err_q <= 1'b1;
    end
  end

  assign o_bus_err = bus_err_q;
`else
  logic unused_cfg;

  assign wait_expired_c = 1'b0;
  assign o_bus_err      = 1'b0;
  assign unused_cfg     = ^{32'(TIMEOUT_CYCLES), trap_timeout_c};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one instruction per directed sequence,
// every cycle's full output vector compared against hand-computed values.
module tb_multicycle_ctrl;

`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  localparam logic [2:0] F_I = 3'd0, F_S = 3'd1, F_B = 3'd2, F_J = 3'd4, F_N = 3'd7;

  logic        clk, rst_n;
  logic [31:0] instr;
  logic        br_taken, imem_ack, dmem_ack;
  logic        imem_req, ir_en, dmem_req, dmem_wren, rd_wren, pc_en, pc_sel;
  logic        illegal, bus_err;
  logic [2:0]  imm_sel;
  logic [11:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_instr     (instr),
    .i_br_taken  (br_taken),
    .i_imem_ack  (imem_ack),
    .i_dmem_ack  (dmem_ack),
    .o_imem_req  (imem_req),
    .o_ir_en     (ir_en),
    .o_dmem_req  (dmem_req),
    .o_dmem_wren (dmem_wren),
    .o_imm_sel   (imm_sel),
    .o_rd_wren   (rd_wren),
    .o_pc_en     (pc_en),
    .o_pc_sel    (pc_sel),
    .o_illegal   (illegal),
    .o_bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outs = {imem_req, ir_en, dmem_req, dmem_wren, imm_sel,
                 rd_wren, pc_en, pc_sel, illegal, bus_err};

  // Expected output vector, in the same field order as outs.
  function automatic logic [11:0] ov(input logic req, input logic ir,
                                     input logic dreq, input logic dwr,
                                     input logic [2:0] imm, input logic rd,
                                     input logic pc, input logic ps,
                                     input logic ill, input logic be);
    return {req, ir, dreq, dwr, imm, rd, pc, ps, ill, be};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input logic ia, input logic da,
                     input logic br, input logic [11:0] exp);
    imem_ack = ia;
    dmem_ack = da;
    br_taken = br;
    #1;
    check_eq(tag, {20'd0, outs}, {20'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h0; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #12;
    check_eq("reset", {20'd0, outs}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("boot", 1'b1, 1'b0, 1'b0, 12'd0);

    // addi x1,x0,5: zero-wait fetch, 4 cycles
    instr = 32'h00500093;
    cyc("addi_fetch", 1, 0, 0, ov(1,1,0,0,F_I,0,0,0,0,0));
    cyc("addi_dec",   0, 0, 0, ov(0,0,0,0,F_I,0,0,0,0,0));
    cyc("addi_exec",  0, 0, 0, ov(0,0,0,0,F_I,0,0,0,0,0));
    cyc("addi_wb",    0, 0, 0, ov(0,0,0,0,F_I,1,1,0,0,0));

    // lw: stray dmem ack in DECODE ignored, MEM waits 3 cycles
    instr = 32'h0040A103;
    cyc("lw_fetch", 1, 0, 0, ov(1,1,0,0,F_I,0,0,0,0,0));
    cyc("lw_dec",   0, 1, 0, ov(0,0,0,0,F_I,0,0,0,0,0));
    cyc("lw_exec",  0, 0, 0, ov(0,0,0,0,F_I,0,0,0,0,0));
    cyc("lw_mem1",  0, 0, 0, ov(0,0,1,0,F_I,0,0,0,0,0));
    cyc("lw_mem2",  0, 0, 0, ov(0,0,1,0,F_I,0,0,0,0,0));
    cyc("lw_mem3",  0, 0, 0, ov(0,0,1,0,F_I,0,0,0,0,0));
    cyc("lw_mem4",  0, 1, 0, ov(0,0,1,0,F_I,0,0,0,0,0));
    cyc("lw_wb",    0, 0, 0, ov(0,0,0,0,F_I,1,1,0,0,0));

    // sw: one fetch wait cycle, store retires in the MEM ack cycle
    instr = 32'h0020A423;
    cyc("sw_fwait", 0, 0, 0, ov(1,0,0,0,F_I,0,0,0,0,0));
    cyc("sw_fetch", 1, 0, 0, ov(1,1,0,0,F_I,0,0,0,0,0));
    cyc("sw_dec",   0, 0, 0, ov(0,0,0,0,F_S,0,0,0,0,0));
    cyc("sw_exec",  0, 0, 0, ov(0,0,0,0,F_S,0,0,0,0,0));
    cyc("sw_mem",   0, 1, 0, ov(0,0,1,1,F_S,0,1,0,0,0));

    // beq taken then not taken: 3 cycles each, pc_sel follows comparator
    instr = 32'h00000463;
    cyc("beq1_fetch", 1, 0, 1, ov(1,1,0,0,F_I,0,0,0,0,0));
    cyc("beq1_dec",   0, 0, 1, ov(0,0,0,0,F_B,0,0,0,0,0));
    cyc("beq1_exec",  0, 0, 1, ov(0,0,0,0,F_B,0,1,1,0,0));
    cyc("beq0_fetch", 1, 0, 0, ov(1,1,0,0,F_I,0,0,0,0,0));
    cyc("beq0_dec",   0, 0, 0, ov(0,0,0,0,F_B,0,0,0,0,0));
    cyc("beq0_exec",  0, 0, 0, ov(0,0,0,0,F_B,0,1,0,0,0));

    // jal: WB selects ALU target and writes rd
    instr = 32'h010000EF;
    cyc("jal_fetch", 1, 0, 0, ov(1,1,0,0,F_I,0,0,0,0,0));
    cyc("jal_dec",   0, 0, 0, ov(0,0,0,0,F_J,0,0,0,0,0));
    cyc("jal_exec",  0, 0, 0, ov(0,0,0,0,F_J,0,0,0,0,0));
    cyc("jal_wb",    0, 0, 0, ov(0,0,0,0,F_J,1,1,1,0,0));

    // illegal opcode: TRAP absorbs, acks ignored, o_illegal sticky
    instr = 32'h0000007F;
    cyc("ill_fetch", 1, 0, 0, ov(1,1,0,0,F_I,0,0,0,0,0));
    cyc("ill_dec",   0, 0, 0, ov(0,0,0,0,F_N,0,0,0,0,0));
    cyc("trap1",     1, 1, 0, ov(0,0,0,0,F_I,0,0,0,1,0));
    cyc("trap2",     1, 0, 1, ov(0,0,0,0,F_I,0,0,0,1,0));
    cyc("trap3",     0, 0, 0, ov(0,0,0,0,F_I,0,0,0,1,0));

    // Reset out of TRAP, then async reset in the middle of a fetch
    rst_n = 1'b0; #1;
    check_eq("trap_rst", {20'd0, outs}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    instr = 32'h00500093;
    cyc("boot2", 0, 0, 0, 12'd0);
    imem_ack = 1'b0; #1;
    check_eq("mid_fetch", {20'd0, outs}, {20'd0, ov(1,0,0,0,F_I,0,0,0,0,0)});
    #2; rst_n = 1'b0; #1;
    check_eq("mid_rst", {20'd0, outs}, 32'd0);
    @(posedge clk); #1;
    check_eq("rst_hold", {20'd0, outs}, 32'd0);
    rst_n = 1'b1;
    cyc("boot3",      0, 0, 0, 12'd0);
    cyc("re_fetch",   1, 0, 0, ov(1,1,0,0,F_I,0,0,0,0,0));
    cyc("re_dec",     0, 0, 0, ov(0,0,0,0,F_I,0,0,0,0,0));
    cyc("re_exec",    0, 0, 0, ov(0,0,0,0,F_I,0,0,0,0,0));
    cyc("re_wb",      0, 0, 0, ov(0,0,0,0,F_I,1,1,0,0,0));

`ifdef CTRL_TIMEOUT_EN
    // No ack for 4 fetch cycles: bus error trap
    cyc("to_w1",   0, 0, 0, ov(1,0,0,0,F_I,0,0,0,0,0));
    cyc("to_w2",   0, 0, 0, ov(1,0,0,0,F_I,0,0,0,0,0));
    cyc("to_w3",   0, 0, 0, ov(1,0,0,0,F_I,0,0,0,0,0));
    cyc("to_w4",   0, 0, 0, ov(1,0,0,0,F_I,0,0,0,0,0));
    cyc("to_trap", 1, 0, 0, ov(0,0,0,0,F_I,0,0,0,0,1));
    rst_n = 1'b0; #1;
    check_eq("to_rst", {20'd0, outs}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Ack on the limit cycle wins
    cyc("to_boot", 0, 0, 0, 12'd0);
    cyc("ok_w1",   0, 0, 0, ov(1,0,0,0,F_I,0,0,0,0,0));
    cyc("ok_w2",   0, 0, 0, ov(1,0,0,0,F_I,0,0,0,0,0));
    cyc("ok_w3",   0, 0, 0, ov(1,0,0,0,F_I,0,0,0,0,0));
    cyc("ok_w4",   1, 0, 0, ov(1,1,0,0,F_I,0,0,0,0,0));
    cyc("ok_dec",  0, 0, 0, ov(0,0,0,0,F_I,0,0,0,0,0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
